// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Sequences jump and branch target generation between dispatch and the IFQ.
//   Jumps are redirected one cycle after acceptance. A conditional branch is
//   predicted not-taken: its target and ROB tag are held until the CDB
//   resolves it. A taken resolution raises a one-cycle mispredict pulse and a
//   redirect. Dispatch is stalled while any control transfer is outstanding.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   disp_*              control instruction presented by dispatch
//   cdb_*               common data bus broadcast (tag + branch outcome)
//   flush               external squash, highest priority
//   ifq_redirect_ready  IFQ accepts the redirect this cycle
//   branch_stall        dispatch must hold (combinational from state)
//   ifq_redirect_*      registered redirect request and target PC
//   mispredict_*        registered one-cycle pulse with the branch tag
//   branch_count        saturating count of accepted branches
//   mispredict_count    saturating count of signalled mispredicts
module branch_redirect_ctrl #(
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic             disp_is_jump,
    input  logic             disp_is_branch,
    input  logic [31:0]      disp_pc_plus4,
    input  logic [15:0]      disp_immediate,
    input  logic [25:0]      disp_address,
    input  logic [TAG_W-1:0] disp_rob_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             cdb_branch_taken,
    input  logic             flush,
    input  logic             ifq_redirect_ready,
    output logic             branch_stall,
    output logic             ifq_redirect_valid,
    output logic [31:0]      ifq_redirect_addr,
    output logic             mispredict_valid,
    output logic [TAG_W-1:0] mispredict_tag,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RES = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    logic [TAG_W-1:0] held_tag;

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] address);
        return {pc_plus4[31:28], address, 2'b00};
    endfunction

    // Word offset sign-extended to a byte offset; the add wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm);
        logic signed [31:0] byte_off;
        byte_off = signed'({{14{imm[15]}}, imm, 2'b00});
        return pc_plus4 + $unsigned(byte_off);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    assign branch_stall = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            held_tag           <= '0;
            ifq_redirect_valid <= 1'b0;
            ifq_redirect_addr  <= '0;
            mispredict_valid   <= 1'b0;
            mispredict_tag     <= '0;
            branch_count       <= '0;
            mispredict_count   <= '0;
        end else begin
            // Mispredict is a pulse: only the taken-resolution path raises it.
            mispredict_valid <= 1'b0;
            if (flush) begin
                // Squash drops any pending branch or redirect; counters stay.
                state              <= IDLE;
                ifq_redirect_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (disp_valid) begin
                            if (disp_is_jump) begin
                                ifq_redirect_addr  <= jump_target(disp_pc_plus4, disp_address);
                                ifq_redirect_valid <= 1'b1;
                                state              <= REDIRECT;
                            end else if (disp_is_branch) begin
                                // Target parked in the address register until resolution.
                                ifq_redirect_addr <= branch_target(disp_pc_plus4, disp_immediate);
                                held_tag          <= disp_rob_tag;
                                branch_count      <= sat_inc(branch_count);
                                state             <= WAIT_RES;
                            end
                        end
                    end
                    WAIT_RES: begin
                        if (cdb_valid && (cdb_tag == held_tag)) begin
                            if (cdb_branch_taken) begin
                                ifq_redirect_valid <= 1'b1;
                                mispredict_valid   <= 1'b1;
                                mispredict_tag     <= held_tag;
                                mispredict_count   <= sat_inc(mispredict_count);
                                state              <= REDIRECT;
                            end else begin
                                // Fall-through path is already being fetched.
                                state <= IDLE;
                            end
                        end
                    end
                    REDIRECT: begin
                        if (ifq_redirect_ready) begin
                            ifq_redirect_valid <= 1'b0;
                            state              <= IDLE;
                        end
                    end
                    default: begin
                        ifq_redirect_valid <= 1'b0;
                        state              <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
